// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Purpose  : Responder side of the cache/memory interface. Collects icache
//            and dcache requests from CPUS cache pairs, grants one requester
//            at a time onto the single RAM port and returns wait/load data.
//            A dcache grant is held for up to BURST back-to-back words so a
//            block fetch or writeback is never split by another requester.
// Ports    : CLK, nRST          clock (rising edge), synchronous active-low reset
//            iREN/iaddr         icache read request / word address per CPU
//            iwait/iload        icache wait (1 = not served) / read data
//            dREN/dWEN          dcache read / write request per CPU
//            daddr/dstore       dcache word address / write data per CPU
//            dwait/dload        dcache wait (1 = not served) / read data
//            ramREN/ramWEN      RAM read / write strobes
//            ramaddr/ramstore   RAM address / write data
//            ramload/ramready   RAM read data / access completes this cycle
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int CPUS  = 2,
  parameter int BURST = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [32*CPUS-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [32*CPUS-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [32*CPUS-1:0]   daddr,
  input  logic [32*CPUS-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [32*CPUS-1:0]   dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic                 ramready
);

  localparam int CW  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int WCW = $clog2(BURST) + 1;
  localparam logic [WCW-1:0] c_burst    = WCW'(BURST);
  localparam logic [CW-1:0]  c_last_cpu = CW'(CPUS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_DW = 2'd1,
                            SRC_DR = 2'd2, SRC_IR = 2'd3} src_t;

  state_t          r_state;
  src_t            r_gnt_src;
  logic [CW-1:0]   r_gnt_cpu;
  logic [WCW-1:0]  r_word_cnt;
  logic [CW-1:0]   r_rr;

  logic [31:0]     w_iaddr  [CPUS];
  logic [31:0]     w_daddr  [CPUS];
  logic [31:0]     w_dstore [CPUS];

  logic [CPUS-1:0] w_sel_mask;
  src_t            w_sel_src;
  logic [CW-1:0]   w_sel_cpu;
  logic            w_found;
  logic            w_active;
  logic            w_more_words;
  logic [CW-1:0]   w_rr_next;

  // Split the flat per-CPU buses into word arrays for the grant muxes.
  generate
    for (genvar n = 0; n < CPUS; n++) begin : g_unpack
      assign w_iaddr[n]  = iaddr[32*n +: 32];
      assign w_daddr[n]  = daddr[32*n +: 32];
      assign w_dstore[n] = dstore[32*n +: 32];
    end
  endgenerate

  // Read data is broadcast; a cache only consumes it while its wait is low.
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  // Request selection: pick the highest-priority class that has any request,
  // then the first requester at or after r_rr, wrapping around. A CPU raising
  // both dWEN and dREN is seen as a writer only.
  always_comb begin
    w_sel_mask = '0;
    w_sel_src  = SRC_NONE;
    w_sel_cpu  = '0;
    w_found    = 1'b0;
    if (|dWEN) begin
      w_sel_mask = dWEN;
      w_sel_src  = SRC_DW;
    end else if (|(dREN & ~dWEN)) begin
      w_sel_mask = dREN & ~dWEN;
      w_sel_src  = SRC_DR;
    end else if (|iREN) begin
      w_sel_mask = iREN;
      w_sel_src  = SRC_IR;
    end
    // First pass covers indices r_rr..CPUS-1, second pass the wrapped part.
    for (int j = 0; j < CPUS; j++) begin
      if (!w_found && w_sel_mask[j] && (CW'(j) >= r_rr)) begin
        w_found   = 1'b1;
        w_sel_cpu = CW'(j);
      end
    end
    for (int j = 0; j < CPUS; j++) begin
      if (!w_found && w_sel_mask[j]) begin
        w_found   = 1'b1;
        w_sel_cpu = CW'(j);
      end
    end
  end

  // RAM port and wait decode from the current grant. The address and store
  // data follow the live cache inputs so a burst picks up the next word.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    w_active = 1'b0;
    if (r_state == S_ACCESS) begin
      case (r_gnt_src)
        SRC_DW:  w_active = dWEN[r_gnt_cpu];
        SRC_DR:  w_active = dREN[r_gnt_cpu];
        SRC_IR:  w_active = iREN[r_gnt_cpu];
        default: w_active = 1'b0;
      endcase
      if (w_active) begin
        ramREN  = (r_gnt_src == SRC_DR) || (r_gnt_src == SRC_IR);
        ramWEN  = (r_gnt_src == SRC_DW);
        ramaddr = (r_gnt_src == SRC_IR) ? w_iaddr[r_gnt_cpu] : w_daddr[r_gnt_cpu];
        if (r_gnt_src == SRC_DW) begin
          ramstore = w_dstore[r_gnt_cpu];
        end
        if (ramready) begin
          if (r_gnt_src == SRC_IR) begin
            iwait[r_gnt_cpu] = 1'b0;
          end else begin
            dwait[r_gnt_cpu] = 1'b0;
          end
        end
      end
    end
  end

  assign w_more_words = ((r_gnt_src == SRC_DR) || (r_gnt_src == SRC_DW)) &&
                        ((r_word_cnt + 1'b1) < c_burst);
  assign w_rr_next    = (r_gnt_cpu == c_last_cpu) ? '0 : (r_gnt_cpu + 1'b1);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state    <= S_IDLE;
      r_gnt_cpu  <= '0;
      r_gnt_src  <= SRC_NONE;
      r_word_cnt <= '0;
      r_rr       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt_cpu  <= w_sel_cpu;
            r_gnt_src  <= w_sel_src;
            r_word_cnt <= '0;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!w_active) begin
            // Requester withdrew: release without a response, rr unchanged.
            r_state    <= S_IDLE;
            r_gnt_src  <= SRC_NONE;
            r_word_cnt <= '0;
          end else if (ramready) begin
            if (w_more_words) begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end else begin
              r_state    <= S_IDLE;
              r_gnt_src  <= SRC_NONE;
              r_word_cnt <= '0;
              r_rr       <= w_rr_next;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
